// File: rtl/instr_encoder.sv
// RV32I instruction assembler: packs decoded fields and a byte immediate into an
// instruction word, validates the immediate, and streams legal words into IMEM.
module instr_encoder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    output logic                  imem_we,
    input  logic                  imem_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err_valid,
    output logic [1:0]            err_code
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [1:0] ERR_RANGE = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_ULOW  = 2'd2;
    localparam logic [1:0] ERR_OPC   = 2'd3;

    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic                  err_valid_q;
    logic [1:0]            err_code_q;

    logic signed [31:0] simm;
    logic               is_shift;
    logic [31:0]        enc_word;
    logic               enc_bad;
    logic [1:0]         enc_code;
    logic               accept;
    logic               fire;

    assign simm     = $signed(in_imm);
    assign is_shift = (in_opcode == OP_IMM) && (in_funct3[1:0] == 2'b01);

    // Handshake: a bundle transfers on a rising edge where in_valid && in_ready;
    // a write retires on a rising edge where imem_we && imem_ready. Both may
    // happen on the same edge, so back-to-back bundles stream without bubbles.
    assign in_ready = !rst && !clear && !full && (!we_q || imem_ready);
    assign accept   = in_valid && in_ready;
    assign fire     = we_q && imem_ready;

    always_comb begin
        enc_word = '0;
        enc_bad  = 1'b0;
        enc_code = ERR_RANGE;
        case (in_opcode)
            OP_LOAD, OP_IMM, OP_JALR: begin
                if (is_shift) begin
                    enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_bad  = (in_imm > 32'd31);
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_bad  = (simm < -2048) || (simm > 2047);
                end
            end
            OP_STORE: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_bad  = (simm < -2048) || (simm > 2047);
            end
            OP_BRANCH: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                if ((simm < -4096) || (simm > 4094)) begin
                    enc_bad = 1'b1;
                end else if (in_imm[0]) begin
                    enc_bad  = 1'b1;
                    enc_code = ERR_ALIGN;
                end
            end
            OP_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                if ((simm < -1048576) || (simm > 1048574)) begin
                    enc_bad = 1'b1;
                end else if (in_imm[0]) begin
                    enc_bad  = 1'b1;
                    enc_code = ERR_ALIGN;
                end
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                enc_bad  = (in_imm[11:0] != 12'd0);
                enc_code = ERR_ULOW;
            end
            OP_OP: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            default: begin
                enc_bad  = 1'b1;
                enc_code = ERR_OPC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            err_valid_q <= 1'b0;
            if (fire) begin
                ptr_q <= ptr_q + 1'b1;
                cnt_q <= cnt_q + 1'b1;
            end
            // A rejected bundle still retires any write that completes on this edge.
            if (accept) begin
                if (enc_bad) begin
                    we_q        <= 1'b0;
                    err_valid_q <= 1'b1;
                    err_code_q  <= enc_code;
                end else begin
                    we_q    <= 1'b1;
                    wdata_q <= enc_word;
                end
            end else if (fire) begin
                we_q <= 1'b0;
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = ptr_q;
    assign imem_wdata = wdata_q;
    assign count      = cnt_q;
    assign full       = (cnt_q == FULL_CNT);
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate generator: accepts decoded instruction fields (opcode, registers, funct, 32-bit signed immediate) and assembles the RV32I instruction word.
- Scatters the immediate into the I/S/B/J/U bit layout selected by the opcode.
- Range/alignment-checks the immediate, then writes legal words into instruction memory at an auto-incrementing word address.
- Used by the scratch program loader and self-test benches to build programs in IMEM without a host assembler.

Parameters:
- ADDR_WIDTH, 10, IMEM word-address width; depth = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- clear  input  1  synchronous pulse: write pointer and count to 0, pending word dropped.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle this cycle.
- in_opcode  input  7  RV32I opcode.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3.
- in_funct7  input  7  funct7 (R-type and shift-immediate only).
- in_imm  input  32  signed immediate, full byte value (U-type: the full upper value, low 12 bits must be 0).
- imem_we  output  1  write request.
- imem_ready  input  1  IMEM accepts write this cycle.
- imem_addr  output  ADDR_WIDTH  word address.
- imem_wdata  output  32  encoded instruction.
- count  output  ADDR_WIDTH+1  words written since reset/clear.
- full  output  1  count == 2^ADDR_WIDTH.
- err_valid  output  1  one-cycle pulse, bundle rejected.
- err_code  output  2  0 imm out of range, 1 imm misaligned, 2 U-type low bits nonzero, 3 unknown opcode.

Behaviour:
- Reset values: in_ready 0 during rst; imem_we 0, imem_addr 0, imem_wdata 0, count 0, full 0, err_valid 0, err_code 0.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !rst && !clear && !full && (!imem_we || imem_ready).
- Latency:
  - A legal bundle accepted in cycle N gives imem_we=1 with addr/wdata in cycle N+1.
  - While imem_we && !imem_ready, imem_we/addr/wdata hold stable.
  - On imem_we && imem_ready: pointer and count increment; a new bundle may be accepted in the same cycle (full throughput).
- Encoding, opcode to format:
  - LOAD 0000011, OP_IMM 0010011, JALR 1100111: I-type.
  - STORE 0100011: S-type.
  - BRANCH 1100011: B-type.
  - JAL 1101111: J-type.
  - LUI 0110111, AUIPC 0010111: U-type.
  - OP 0110011: R-type, in_imm ignored, no checks.
  - Any other opcode: err_code 3.
- Bit placement:
  - I-type: [31:20]=imm[11:0].
  - S-type: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B-type: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J-type: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U-type: [31:12]=imm[31:12].
  - Fields not used by a format are zero.
- Shift immediates (OP_IMM, funct3 001/101): [31:25]=in_funct7, [24:20]=imm[4:0]; imm must be 0..31, else code 0.
- Range checks, signed, on in_imm:
  - I/S: -2048..2047.
  - B: -4096..4094.
  - J: -1048576..1048574.
  - B/J with imm[0]=1: code 1. Range has priority over alignment when both fail.
- Error handling: the bundle is consumed (in_ready behaves normally) but no write occurs. err_valid pulses in cycle N+1; pointer and count are unchanged.
- Full: pointer wraps to 0 exactly as count reaches 2^ADDR_WIDTH. full then holds in_ready low until clear or rst.
- clear:
  - Has priority over everything except rst.
  - Cancels a pending or stalled write: imem_we goes to 0 next cycle even if imem_ready is 0.
  - A bundle presented in the clear cycle is not accepted.
- rst mid-write: same effect as clear plus all outputs go to reset values.

Test Plan:
- addi x1,x0,5 (OP_IMM, f3 0, imm 5) after reset -> next cycle imem_we=1, addr 0, wdata 0x00500093; count 1.
- sw x2,8(x1) then beq x0,x0,-4 back-to-back, imem_ready=1 -> wdata 0x0020A423 at addr 0, 0xFE000EE3 at addr 1, no bubble.
- jal x1,2048 then lui x5,0x12345000, with imem_ready low 3 cycles on the first write -> 0x001000EF held stable, in_ready low during the stall, then 0x123452B7 at addr 1.
- Illegal bundles:
  - addi imm 2048 -> err_valid pulse, code 0, no write.
  - beq imm 3 -> code 1.
  - lui imm 0x00001001 -> code 2.
  - opcode 0x7F -> code 3.
  - count unchanged in every case.
- ADDR_WIDTH=2: four writes -> full=1, in_ready=0, count=4, addr wraps to 0; a fifth in_valid is not accepted; clear -> full=0, count 0, next write at addr 0.
- clear while imem_we && !imem_ready -> imem_we=0 next cycle, no write completes, count 0.
